// File: rtl/eth_rx_fcs_check.sv
// ---------------------------------------------------------------------------
// eth_rx_fcs_check
//
// Purpose:
//   Receive-side frame checker between the RMII MAC (dibit stream) and the
//   packet-buffer writer. It packs dibits into bytes and runs a reflected
//   CRC-32 over every byte, FCS included. A 4-byte delay line holds back
//   the newest four bytes. When the frame ends those four bytes are the
//   FCS, so they are never forwarded. At end of frame a one-cycle status
//   beat reports the payload length and the error flags. The buffer stage
//   uses it to commit or drop the frame.
//
// Ports:
//   clk          system clock (RMII 50 MHz reference domain)
//   rst          synchronous active-high reset
//   rx_axi_valid dibit valid; one contiguous high run per frame
//   rx_axi_data  received dibit; the first dibit of a byte is bits [1:0]
//   out_valid    one-cycle strobe, out_data holds a payload byte
//   out_data     payload byte in wire order
//   frame_done   one-cycle strobe, status outputs below are valid
//   frame_ok     no error flag set
//   err_crc      CRC residue mismatch
//   err_align    dibit count was not a multiple of 4
//   err_len      total byte count outside [MIN_FRAME, MAX_FRAME]
//   frame_len    payload bytes forwarded (total bytes - 4, floor 0)
// ---------------------------------------------------------------------------
module eth_rx_fcs_check #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int LEN_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_axi_valid,
    input  logic [1:0]       rx_axi_data,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             err_crc,
    output logic             err_align,
    output logic             err_len,
    output logic [LEN_W-1:0] frame_len
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam logic [LEN_W-1:0] LEN_FCS     = LEN_W'(4);
    localparam logic [LEN_W-1:0] LEN_MIN     = LEN_W'(MIN_FRAME);
    localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(MAX_FRAME);
    localparam logic [LEN_W-1:0] LEN_MAX_PAY = LEN_W'(MAX_FRAME - 4);

    typedef enum logic [1:0] {
        SKIP,
        IDLE,
        RECV,
        DROP
    } state_t;

    state_t           state;
    logic [1:0]       dibit_cnt;
    logic [5:0]       byte_sh;
    logic [LEN_W-1:0] byte_cnt;
    logic [31:0]      crc;
    logic [3:0][7:0]  dly;

    logic [7:0]       full_byte;
    logic [31:0]      crc_next;
    logic             byte_end;
    logic             end_err_align;
    logic             end_err_crc;
    logic             end_err_len;
    logic [LEN_W-1:0] end_len;

    // Reflected CRC-32 update for one byte, LSB first, matching wire order.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // The byte is complete on the cycle its 4th dibit is present. The
    // shift register already holds the first three dibits, LSB first.
    always_comb begin
        full_byte = {rx_axi_data, byte_sh};
        crc_next  = crc_byte(crc, full_byte);
        byte_end  = rx_axi_valid && (dibit_cnt == 2'd3);
    end

    // End-of-frame status for a frame that stayed within MAX_FRAME. Only
    // complete bytes count toward the length. A trailing partial byte never
    // reached the CRC, so it only shows up as an alignment error.
    always_comb begin
        end_err_align = (dibit_cnt != 2'd0);
        end_err_crc   = (crc != CRC_RESIDUE);
        end_err_len   = (byte_cnt < LEN_MIN);
        end_len       = (byte_cnt >= LEN_FCS) ? (byte_cnt - LEN_FCS) : '0;
    end

    // Main frame FSM. Byte assembly, CRC, the delay line and every output
    // are registered here. out_valid and frame_done default low, so each is
    // a single-cycle strobe. The status outputs hold their value between
    // frames. The FCS is never forwarded because the delay line keeps the
    // last four bytes back. Byte k releases byte k-4 on the same edge that
    // samples byte k's last dibit. Reset has priority, so any frame_done
    // due on that edge is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SKIP;
            dibit_cnt  <= '0;
            byte_sh    <= '0;
            byte_cnt   <= '0;
            crc        <= CRC_INIT;
            dly        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_crc    <= 1'b0;
            err_align  <= 1'b0;
            err_len    <= 1'b0;
            frame_len  <= '0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                // Reset may release mid-frame. Discard that frame by waiting
                // for the line to go quiet before looking for a start.
                SKIP: begin
                    if (!rx_axi_valid) begin
                        state <= IDLE;
                    end
                end

                // Clearing happens here every cycle, so a frame can start
                // on the cycle right after the previous frame's frame_done
                // edge without inheriting any state. The first dibit is
                // captured directly.
                IDLE: begin
                    byte_cnt <= '0;
                    crc      <= CRC_INIT;
                    dly      <= '0;
                    if (rx_axi_valid) begin
                        dibit_cnt <= 2'd1;
                        byte_sh   <= {rx_axi_data, 4'd0};
                        state     <= RECV;
                    end else begin
                        dibit_cnt <= '0;
                        byte_sh   <= '0;
                    end
                end

                // Byte index MAX_FRAME is the first byte past the legal
                // maximum. It is not forwarded, and the frame switches to
                // DROP.
                RECV: begin
                    if (rx_axi_valid) begin
                        dibit_cnt <= dibit_cnt + 2'd1;
                        byte_sh   <= {rx_axi_data, byte_sh[5:2]};
                        if (byte_end) begin
                            crc      <= crc_next;
                            dly      <= {dly[2:0], full_byte};
                            byte_cnt <= byte_cnt + LEN_W'(1);
                            if (byte_cnt == LEN_MAX) begin
                                state <= DROP;
                            end else if (byte_cnt >= LEN_FCS) begin
                                out_valid <= 1'b1;
                                out_data  <= dly[3];
                            end
                        end
                    end else begin
                        frame_done <= 1'b1;
                        err_align  <= end_err_align;
                        err_crc    <= end_err_crc;
                        err_len    <= end_err_len;
                        frame_ok   <= !(end_err_align || end_err_crc || end_err_len);
                        frame_len  <= end_len;
                        state      <= IDLE;
                    end
                end

                // Oversized frame. Nothing more is forwarded or added to the
                // CRC. The dibit phase is still tracked so alignment is still
                // reported. The length reads as the forwarded maximum.
                DROP: begin
                    if (rx_axi_valid) begin
                        dibit_cnt <= dibit_cnt + 2'd1;
                    end else begin
                        frame_done <= 1'b1;
                        err_align  <= end_err_align;
                        err_crc    <= end_err_crc;
                        err_len    <= 1'b1;
                        frame_ok   <= 1'b0;
                        frame_len  <= LEN_MAX_PAY;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= SKIP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_fcs_check
//
// Directed frames are streamed into eth_rx_fcs_check. As each dibit is
// driven, the stimulus side queues the payload beat it should produce,
// tagged with the cycle it should appear in. At the end of each frame it
// queues the expected status beat the same way. A monitor on the falling
// edge pops and compares whenever out_valid or frame_done is high.
// ---------------------------------------------------------------------------
module tb_eth_rx_fcs_check;

    localparam int MIN_FRAME = 64;
    localparam int MAX_FRAME = 1518;
    localparam int LEN_W     = 11;

    logic             clk;
    logic             rst;
    logic             rx_axi_valid;
    logic [1:0]       rx_axi_data;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             frame_done;
    logic             frame_ok;
    logic             err_crc;
    logic             err_align;
    logic             err_len;
    logic [LEN_W-1:0] frame_len;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } beat_t;

    typedef struct {
        logic [LEN_W-1:0] len;
        logic             len_e;
        logic             align;
        logic             crc_e;
        logic             ok;
        bit               chk_crc;
        int               cyc;
    } status_t;

    beat_t      beat_q[$];
    status_t    stat_q[$];
    logic [7:0] frm[$];

    int cyc        = 0;
    int checks     = 0;
    int passes     = 0;
    int exp_beats  = 0;
    int exp_dones  = 0;
    int seen_beats = 0;
    int seen_dones = 0;

    eth_rx_fcs_check #(
        .MIN_FRAME(MIN_FRAME),
        .MAX_FRAME(MAX_FRAME),
        .LEN_W    (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_axi_valid(rx_axi_valid),
        .rx_axi_data (rx_axi_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .err_crc     (err_crc),
        .err_align   (err_align),
        .err_len     (err_len),
        .frame_len   (frame_len)
    );

    // 50 MHz clock and a free-running cycle index used to time-stamp beats.
    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard time limit so a stuck run still ends with a FAIL line.
    initial begin
        #(20 * 60000);
        $display("[TB] FAIL watchdog: time limit reached, beats seen %0d of %0d", seen_beats, exp_beats);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reflected CRC-32 byte update used to build correct FCS fields.
    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // One comparison: counts it, and prints a FAIL line on a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Fills frm with n payload bytes (start+i) and, if asked, appends the
    // FCS, least significant byte first.
    task automatic buildFrame(input int n, input int start, input bit add_fcs);
        logic [31:0] c;
        logic [31:0] fcs;
        frm.delete();
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            frm.push_back(8'((start + i) & 8'hFF));
            c = crcByte(c, 8'((start + i) & 8'hFF));
        end
        if (add_fcs) begin
            fcs = ~c;
            for (int i = 0; i < 4; i++) begin
                frm.push_back(fcs[8*i +: 8]);
            end
        end
    endtask

    // Streams frm as dibits, then sends extra_dibits trailing dibits and
    // one cycle with valid low. If rst_at >= 0, rst is held for 3 cycles
    // starting at that byte. Queueing stops there, because the rest of
    // that frame must produce nothing.
    task automatic applyStimulus(input int extra_dibits, input int rst_at,
                                 input bit chk_crc, input logic exp_crc);
        bit      aborted;
        int      rst_left;
        int      total;
        status_t s;
        aborted  = 0;
        rst_left = 0;
        total    = frm.size();
        for (int k = 0; k < total; k++) begin
            for (int j = 0; j < 4; j++) begin
                @(posedge clk);
                #1;
                if (k == rst_at && j == 0) begin
                    aborted  = 1;
                    rst_left = 3;
                end
                rst = (rst_left > 0);
                if (rst_left > 0) rst_left--;
                rx_axi_valid = 1'b1;
                rx_axi_data  = frm[k][2*j +: 2];
                if (!aborted && j == 3 && k >= 4 && k < MAX_FRAME) begin
                    beat_q.push_back('{data: frm[k-4], cyc: cyc + 1});
                    exp_beats++;
                end
            end
        end
        for (int e = 0; e < extra_dibits; e++) begin
            @(posedge clk);
            #1;
            rx_axi_valid = 1'b1;
            rx_axi_data  = 2'(e + 1);
        end
        @(posedge clk);
        #1;
        rst          = 1'b0;
        rx_axi_valid = 1'b0;
        rx_axi_data  = 2'd0;
        if (!aborted) begin
            s.len_e   = (total < MIN_FRAME) || (total > MAX_FRAME);
            s.len     = (total > MAX_FRAME) ? LEN_W'(MAX_FRAME - 4)
                      : (total >= 4)        ? LEN_W'(total - 4) : '0;
            s.align   = (extra_dibits % 4) != 0;
            s.crc_e   = exp_crc;
            s.chk_crc = chk_crc;
            s.ok      = !(s.len_e || s.align || (chk_crc && exp_crc));
            s.cyc     = cyc + 1;
            stat_q.push_back(s);
            exp_dones++;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare each presented beat or status against the queue
    // head. Expected items whose cycle has passed unseen are reported as
    // missing.
    always @(negedge clk) begin
        while (beat_q.size() > 0 && beat_q[0].cyc < cyc) begin
            checkOutput("beat_missing_cycle", 64'(cyc), 64'(beat_q[0].cyc));
            void'(beat_q.pop_front());
        end
        while (stat_q.size() > 0 && stat_q[0].cyc < cyc) begin
            checkOutput("done_missing_cycle", 64'(cyc), 64'(stat_q[0].cyc));
            void'(stat_q.pop_front());
        end
        if (out_valid) begin
            beat_t b;
            seen_beats++;
            if (beat_q.size() == 0) begin
                checkOutput("unexpected_beat_count", 64'(seen_beats), 64'(exp_beats));
            end else begin
                b = beat_q.pop_front();
                checkOutput("beat_cycle", 64'(cyc), 64'(b.cyc));
                checkOutput("beat_data", 64'(out_data), 64'(b.data));
            end
        end
        if (frame_done) begin
            status_t s;
            seen_dones++;
            if (stat_q.size() == 0) begin
                checkOutput("unexpected_done_count", 64'(seen_dones), 64'(exp_dones));
            end else begin
                s = stat_q.pop_front();
                checkOutput("done_cycle", 64'(cyc), 64'(s.cyc));
                checkOutput("frame_len", 64'(frame_len), 64'(s.len));
                checkOutput("err_len", 64'(err_len), 64'(s.len_e));
                checkOutput("err_align", 64'(err_align), 64'(s.align));
                checkOutput("frame_ok", 64'(frame_ok), 64'(s.ok));
                if (s.chk_crc) checkOutput("err_crc", 64'(err_crc), 64'(s.crc_e));
            end
        end
    end

    // Main sequence of directed frames.
    initial begin
        logic [31:0] c;
        logic [71:0] ascii;
        rst          = 1'b1;
        rx_axi_valid = 1'b0;
        rx_axi_data  = 2'd0;

        // Check the bench's own CRC model against the standard check value.
        ascii = "123456789";
        c = 32'hFFFF_FFFF;
        for (int i = 8; i >= 0; i--) c = crcByte(c, ascii[8*i +: 8]);
        if (~c != 32'hCBF4_3926) begin
            $display("[TB] FAIL bench_crc_model: got %08h, expected cbf43926", ~c);
            $fatal(1, "[TB] CRC model broken");
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_frame_done", 64'(frame_done), 64'd0);
        checkOutput("reset_frame_ok", 64'(frame_ok), 64'd0);
        checkOutput("reset_errs", 64'({err_crc, err_align, err_len}), 64'd0);
        checkOutput("reset_frame_len", 64'(frame_len), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycles(3);

        $display("[TB] good 64-byte frame");
        buildFrame(60, 0, 1);
        applyStimulus(0, -1, 1, 1'b0);
        idleCycles(3);

        $display("[TB] 64-byte frame, payload byte 20 bit 3 flipped");
        buildFrame(60, 0, 1);
        frm[20] = frm[20] ^ 8'h08;
        applyStimulus(0, -1, 1, 1'b1);
        idleCycles(3);

        $display("[TB] good 64-byte frame plus one trailing dibit");
        buildFrame(60, 0, 1);
        applyStimulus(1, -1, 1, 1'b0);
        idleCycles(3);

        $display("[TB] 40-byte frame with correct FCS");
        buildFrame(36, 8'h40, 1);
        applyStimulus(0, -1, 1, 1'b0);
        idleCycles(3);

        $display("[TB] 1600-byte frame");
        buildFrame(1596, 8'h11, 1);
        applyStimulus(0, -1, 0, 1'b0);
        idleCycles(3);

        $display("[TB] 3-byte frame");
        buildFrame(3, 8'hA0, 0);
        applyStimulus(0, -1, 0, 1'b0);
        idleCycles(3);

        $display("[TB] reset in the middle of a 100-byte frame, then good frame after 1-cycle gap");
        buildFrame(96, 8'h22, 1);
        applyStimulus(0, 50, 1, 1'b0);
        buildFrame(60, 8'h80, 1);
        applyStimulus(0, -1, 1, 1'b0);
        idleCycles(3);

        $display("[TB] two good 64-byte frames with a 1-cycle gap");
        buildFrame(60, 8'h05, 1);
        applyStimulus(0, -1, 1, 1'b0);
        buildFrame(60, 8'hC3, 1);
        applyStimulus(0, -1, 1, 1'b0);

        idleCycles(10);
        checkOutput("beats_total", 64'(seen_beats), 64'(exp_beats));
        checkOutput("dones_total", 64'(seen_dones), 64'(exp_dones));
        checkOutput("beat_queue_left", 64'(beat_q.size()), 64'd0);
        checkOutput("done_queue_left", 64'(stat_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/eth_rx_fcs_check.md
Name: eth_rx_fcs_check

Overview:
Streaming frame checker between the RMII receive MAC (dibit AXI-style output) and the receive packet-buffer interface. It packs dibits into bytes and runs CRC-32 over every byte. A 4-byte delay line strips the FCS, so only payload bytes (DST MAC through last data byte) are forwarded. At end of frame it emits a one-cycle status beat with length and error flags, so the buffer stage can commit or drop the frame before ringing its doorbell.

Parameters:
MIN_FRAME, 64, minimum legal frame length in bytes including FCS
MAX_FRAME, 1518, maximum legal frame length in bytes including FCS (matches ETH_MTU)
LEN_W, 11, width of the frame_len and internal byte counters

Ports:
clk  in  1  system clock (50 MHz RMII reference clock domain)
rst  in  1  synchronous active-high reset
rx_axi_valid  in  1  dibit valid from MAC; a frame is one contiguous high run
rx_axi_data  in  2  received dibit; first dibit of each byte is bits [1:0]
out_valid  out  1  one-cycle strobe: out_data holds a payload byte
out_data  out  8  payload byte, in wire order
frame_done  out  1  one-cycle strobe: frame ended, status outputs valid this cycle
frame_ok  out  1  frame_done qualifier: no error flag set
err_crc  out  1  CRC residue mismatch
err_align  out  1  dibit count not a multiple of 4
err_len  out  1  total bytes < MIN_FRAME or > MAX_FRAME
frame_len  out  LEN_W  payload bytes emitted (total bytes minus 4, floor 0)

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: all outputs 0, CRC register 0xFFFFFFFF, counters 0, state SKIP.
- There is no backpressure. The consumer must accept every out_valid beat. Status outputs are valid only while frame_done=1 and hold their last value otherwise.
- CRC: reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF, updated per byte (or per dibit, equivalently) over all bytes including FCS.
  - A good frame leaves residue 0xDEBB20E3 in the register.
- Byte assembly: a 2-bit dibit counter increments on each valid cycle. On the 4th dibit the byte completes; CRC and the byte counter update the next cycle.
- Delay line: 4-byte shift register. When byte k (0-indexed) completes and k>=4, byte k-4 is emitted with out_valid, exactly 1 cycle after byte k's last dibit is sampled. The final 4 bytes (FCS) are never emitted.
- States:
  - SKIP: entered after reset. Waits for rx_axi_valid=0, then goes to IDLE. Any partial frame in progress at reset release is discarded with no frame_done.
  - IDLE: counters, delay line and CRC are cleared. When rx_axi_valid=1, the dibit is taken as the first of a new frame and the state goes to RECV.
  - RECV: accumulates dibits.
    - On valid low, the state goes to IDLE and frame_done pulses on the next cycle.
    - If the byte count reaches MAX_FRAME+1, the state goes to DROP. Byte MAX_FRAME+1 is not emitted, so at most MAX_FRAME-4 = 1514 bytes are forwarded.
  - DROP: no out_valid. On valid low, the state goes to IDLE, frame_done pulses with err_len=1 and frame_len=MAX_FRAME-4.
- Error evaluation at frame end:
  - err_align: dibit counter != 0.
  - err_len: total < MIN_FRAME, or DROP was entered.
  - err_crc: residue != 0xDEBB20E3. A trailing partial byte is excluded from the CRC.
  - frame_ok = none of the error flags set.
- Simultaneous events:
  - A new frame may start in the same cycle frame_done pulses (1-cycle gap). IDLE clears state in that cycle, so no loss occurs.
  - rst overrides everything; a frame_done that would fire that cycle is suppressed.
- Frames with fewer than 4 bytes: frame_len=0, no out_valid, err_len=1.

Test Plan:
- 64-byte frame (60 payload bytes 0x00..0x3B plus correct FCS) -> 60 out_valid beats with matching data, first beat 1 cycle after the 5th byte's last dibit; frame_done with frame_ok=1, frame_len=60, all err=0.
- Same frame with bit 3 of payload byte 20 flipped -> 60 beats emitted; frame_done with err_crc=1, frame_ok=0.
- 64-byte good frame followed by 1 extra dibit -> err_align=1, err_crc=0, frame_len=60.
- 40-byte frame with correct FCS -> 36 beats; err_len=1, err_crc=0. A 1600-byte frame -> exactly 1514 beats; err_len=1, frame_len=1514.
- Assert rst for 3 cycles midway through a 100-byte frame -> no frame_done for that frame. The next good 64-byte frame after a 1-cycle gap -> frame_ok=1, frame_len=60.
- Two good 64-byte frames separated by a 1-cycle valid-low gap -> 120 beats total, two frame_done pulses, both frame_ok=1.
